// File: rtl/exec_result_buffer.sv
// Per-execution-unit result queue: a circular FIFO that holds completed results
// until the execute-output arbiter grants this lane.
module exec_result_buffer #(
    parameter int ROBsize    = 8,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int DEPTH      = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       valid_i,
    input  logic [63:0]                data_i,
    input  logic [9:0]                 commands_i,
    input  logic [ROBsizeLog-1:0]      tag_i,
    input  logic [3:0]                 flags_i,
    output logic                       ready_o,
    input  logic                       flush_i,
    input  logic                       canGo_i,
    output logic                       valid_o,
    output logic [63:0]                data_o,
    output logic [9:0]                 commands_o,
    output logic [ROBsizeLog-1:0]      tag_o,
    output logic [3:0]                 flags_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int ENTW = 64 + 10 + ROBsizeLog + 4;

    typedef struct packed {
        logic [63:0]           data;
        logic [9:0]            commands;
        logic [ROBsizeLog-1:0] tag;
        logic [3:0]            flags;
    } entry_t;

    logic [ENTW-1:0] r_mem [DEPTH];
    logic [PTRW-1:0] r_wrPtr;
    logic [PTRW-1:0] r_rdPtr;
    logic [CNTW-1:0] r_count;

    logic   w_full;
    logic   w_nonEmpty;
    logic   w_enq;
    logic   w_deq;
    entry_t w_inEntry;
    entry_t w_headEntry;

    // Handshake decisions use registered occupancy only, so a full buffer
    // stays not-ready even on a cycle where the head is being drained.
    assign w_full     = (r_count == CNTW'(DEPTH));
    assign w_nonEmpty = (r_count != '0);
    assign w_enq      = valid_i && !w_full && !flush_i;
    assign w_deq      = w_nonEmpty && canGo_i && !flush_i;

    assign w_inEntry.data     = data_i;
    assign w_inEntry.commands = commands_i;
    assign w_inEntry.tag      = tag_i;
    assign w_inEntry.flags    = flags_i;

    assign w_headEntry = entry_t'(r_mem[r_rdPtr]);

    // Pointers and occupancy; DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wrPtr <= r_wrPtr + PTRW'(1);
            end
            if (w_deq) begin
                r_rdPtr <= r_rdPtr + PTRW'(1);
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + CNTW'(1);
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - CNTW'(1);
            end
        end
    end

    // Entry storage is deliberately left uncleared; stale contents are masked by count.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wrPtr] <= w_inEntry;
        end
    end

    always_comb begin
        ready_o    = !w_full;
        valid_o    = w_nonEmpty;
        count_o    = r_count;
        data_o     = '0;
        commands_o = '0;
        tag_o      = '0;
        flags_o    = '0;
        if (w_nonEmpty) begin
            data_o     = w_headEntry.data;
            commands_o = w_headEntry.commands;
            tag_o      = w_headEntry.tag;
            flags_o    = w_headEntry.flags;
        end
    end

endmodule

// File: tb/tb_exec_result_buffer.sv
// Testbench for exec_result_buffer: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a queue-based model.
module tb_exec_result_buffer;

    localparam int DEPTH = 4;
    localparam int TAGW  = 4;

    logic            clk_i = 1'b0;
    logic            reset_i, valid_i, flush_i, canGo_i;
    logic [63:0]     data_i;
    logic [9:0]      commands_i;
    logic [TAGW-1:0] tag_i;
    logic [3:0]      flags_i;
    logic            ready_o, valid_o;
    logic [63:0]     data_o;
    logic [9:0]      commands_o;
    logic [TAGW-1:0] tag_o;
    logic [3:0]      flags_o;
    logic [2:0]      count_o;

    int nVec = 0;
    int nMis = 0;

    exec_result_buffer #(.ROBsize(8), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i),
        .commands_i(commands_i), .tag_i(tag_i), .flags_i(flags_i), .ready_o(ready_o),
        .flush_i(flush_i), .canGo_i(canGo_i), .valid_o(valid_o), .data_o(data_o),
        .commands_o(commands_o), .tag_o(tag_o), .flags_o(flags_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [63:0]     d;
        logic [9:0]      c;
        logic [TAGW-1:0] t;
        logic [3:0]      f;
    } ent_t;

    // Reference model: the buffer is simply an ordered list of pending results.
    ent_t modelQ[$];

    typedef struct {
        logic            rst, vld, flush, go;
        logic [63:0]     data;
        logic [TAGW-1:0] tag;
        logic            expValid;
        logic [63:0]     expData;
        logic [TAGW-1:0] expTag;
        logic [2:0]      expCount;
        logic            expReady;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(logic rst, logic vld, logic flush, logic go,
                                logic [63:0] data, logic [TAGW-1:0] tag,
                                logic ev, logic [63:0] ed, logic [TAGW-1:0] et,
                                logic [2:0] ec, logic er);
        vec_t v;
        v.rst = rst; v.vld = vld; v.flush = flush; v.go = go;
        v.data = data; v.tag = tag;
        v.expValid = ev; v.expData = ed; v.expTag = et; v.expCount = ec; v.expReady = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, and clock the DUT.
    task automatic applyStimulus(input logic rst, input logic vld, input logic flush,
                                 input logic go, input logic [63:0] data,
                                 input logic [9:0] cmd, input logic [TAGW-1:0] tag,
                                 input logic [3:0] flg);
        ent_t e;
        bit doDeq, doEnq;
        reset_i = rst; valid_i = vld; flush_i = flush; canGo_i = go;
        data_i = data; commands_i = cmd; tag_i = tag; flags_i = flg;
        e = '{d: data, c: cmd, t: tag, f: flg};
        if (rst || flush) begin
            modelQ.delete();
        end else begin
            doDeq = (modelQ.size() > 0) && go;
            doEnq = vld && (modelQ.size() < DEPTH);
            if (doDeq) void'(modelQ.pop_front());
            if (doEnq) modelQ.push_back(e);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tagName);
        ent_t h;
        h = (modelQ.size() > 0) ? modelQ[0] : '0;
        check({tagName, ".valid"}, 64'(valid_o), 64'(modelQ.size() != 0));
        check({tagName, ".ready"}, 64'(ready_o), 64'(modelQ.size() < DEPTH));
        check({tagName, ".count"}, 64'(count_o), 64'(modelQ.size()));
        check({tagName, ".data"},  data_o, h.d);
        check({tagName, ".cmd"},   64'(commands_o), 64'(h.c));
        check({tagName, ".tag"},   64'(tag_o), 64'(h.t));
        check({tagName, ".flags"}, 64'(flags_o), 64'(h.f));
    endtask

    initial begin
        tbl[0]  = mk(1,0,0,0, 0,     0,  0, 0,     0,  0, 1);
        tbl[1]  = mk(0,0,0,1, 0,     0,  0, 0,     0,  0, 1);
        tbl[2]  = mk(0,1,0,0, 64'hA, 3,  1, 64'hA, 3,  1, 1);
        tbl[3]  = mk(0,0,0,1, 0,     0,  0, 0,     0,  0, 1);
        tbl[4]  = mk(0,1,0,0, 1,     1,  1, 1,     1,  1, 1);
        tbl[5]  = mk(0,1,0,0, 2,     2,  1, 1,     1,  2, 1);
        tbl[6]  = mk(0,1,0,0, 3,     3,  1, 1,     1,  3, 1);
        tbl[7]  = mk(0,1,0,0, 4,     4,  1, 1,     1,  4, 0);
        tbl[8]  = mk(0,1,0,0, 5,     5,  1, 1,     1,  4, 0);
        tbl[9]  = mk(0,0,0,1, 0,     0,  1, 2,     2,  3, 1);
        tbl[10] = mk(0,0,0,1, 0,     0,  1, 3,     3,  2, 1);
        tbl[11] = mk(0,0,0,1, 0,     0,  1, 4,     4,  1, 1);
        tbl[12] = mk(0,0,0,1, 0,     0,  0, 0,     0,  0, 1);
        tbl[13] = mk(0,1,0,0, 7,     7,  1, 7,     7,  1, 1);
        tbl[14] = mk(0,1,0,0, 8,     8,  1, 7,     7,  2, 1);
        tbl[15] = mk(0,1,0,0, 9,     9,  1, 7,     7,  3, 1);
        tbl[16] = mk(0,1,1,1, 10,    10, 0, 0,     0,  0, 1);
        tbl[17] = mk(0,1,0,0, 11,    11, 1, 11,    11, 1, 1);
        tbl[18] = mk(0,0,0,1, 0,     0,  0, 0,     0,  0, 1);

        // Directed table: commands/flags ride along as slices of the data value.
        for (int i = 0; i < 19; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].vld, tbl[i].flush, tbl[i].go,
                          tbl[i].data, tbl[i].data[9:0], tbl[i].tag, tbl[i].data[3:0]);
            check($sformatf("tbl%0d.valid", i), 64'(valid_o), 64'(tbl[i].expValid));
            check($sformatf("tbl%0d.data", i),  data_o, tbl[i].expData);
            check($sformatf("tbl%0d.tag", i),   64'(tag_o), 64'(tbl[i].expTag));
            check($sformatf("tbl%0d.count", i), 64'(count_o), 64'(tbl[i].expCount));
            check($sformatf("tbl%0d.ready", i), 64'(ready_o), 64'(tbl[i].expReady));
            check($sformatf("tbl%0d.cmd", i),   64'(commands_o), 64'(tbl[i].expData[9:0]));
            check($sformatf("tbl%0d.flags", i), 64'(flags_o), 64'(tbl[i].expData[3:0]));
        end

        // Steady-state enqueue+dequeue at count 2, long enough to wrap both pointers.
        applyStimulus(0,1,0,0, 64'd100, 10'd0, 4'd0, 4'd0);
        applyStimulus(0,1,0,0, 64'd101, 10'd1, 4'd1, 4'd1);
        check("wrap.fill.count", 64'(count_o), 64'd2);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0,1,0,1, 64'd102 + 64'(i), 10'(i + 2), 4'((i + 2) % 9), 4'(i));
            check($sformatf("wrap%0d.count", i), 64'(count_o), 64'd2);
            check($sformatf("wrap%0d.data", i),  data_o, 64'd101 + 64'(i));
        end

        // Fill to full, reset mid-operation, and make sure only the new result emerges.
        applyStimulus(0,1,0,0, 64'd200, 10'd0, 4'd0, 4'd0);
        applyStimulus(0,1,0,0, 64'd201, 10'd0, 4'd0, 4'd0);
        check("rst.full.count", 64'(count_o), 64'd4);
        applyStimulus(1,1,1,1, 64'd202, 10'd0, 4'd0, 4'd0);
        check("rst.count", 64'(count_o), 64'd0);
        check("rst.valid", 64'(valid_o), 64'd0);
        applyStimulus(0,1,0,0, 64'h55, 10'h55, 4'd5, 4'h5);
        check("rst.new.data",  data_o, 64'h55);
        check("rst.new.count", 64'(count_o), 64'd1);
        applyStimulus(0,0,0,1, 64'd0, 10'd0, 4'd0, 4'd0);
        check("rst.drain.valid", 64'(valid_o), 64'd0);
        check("rst.drain.data",  data_o, 64'd0);

        // Randomized traffic against the queue model.
        applyStimulus(1,0,0,0, 64'd0, 10'd0, 4'd0, 4'd0);
        checkOutput("rnd.reset");
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 60,
                          $urandom_range(0, 99) < 4,
                          $urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70),
                          {$urandom, $urandom}, 10'($urandom),
                          4'($urandom_range(0, 8)), 4'($urandom));
            checkOutput($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
